// File: rtl/me_frame_scheduler.sv
// Frame-level sequencer for the motion-estimation engine: walks the macroblock
// grid in raster order, driving load / search / result hand-off per block.
module me_frame_scheduler #(
  parameter int MB_COLS = 22,
  parameter int MB_ROWS = 18,
  parameter int SAD_W   = 16,
  parameter int MV_W    = 8,
  parameter int TIMEOUT = 8192
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic [1:0]       r,
  output logic             busy,
  output logic             frame_done,
  output logic             err_timeout,
  output logic             ld_req,
  output logic [7:0]       ld_mbx,
  output logic [7:0]       ld_mby,
  input  logic             ld_ack,
  output logic             me_go,
  output logic [1:0]       me_r,
  input  logic             me_done,
  input  logic [SAD_W-1:0] me_sad,
  input  logic [MV_W-1:0]  me_mvx,
  input  logic [MV_W-1:0]  me_mvy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_mbx,
  output logic [7:0]       res_mby,
  output logic [SAD_W-1:0] res_sad,
  output logic [MV_W-1:0]  res_mvx,
  output logic [MV_W-1:0]  res_mvy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_GO     = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;
  localparam logic [2:0] S_NEXT   = 3'd5;
  localparam logic [2:0] S_FINISH = 3'd6;

  localparam int             WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [7:0]     LAST_COL = 8'(MB_COLS - 1);
  localparam logic [7:0]     LAST_ROW = 8'(MB_ROWS - 1);

  logic [2:0]       state_reg, state_next;
  logic [7:0]       mbx_reg, mby_reg;
  logic [WD_W-1:0]  wd_reg;
  logic [1:0]       me_r_reg;
  logic             err_reg;
  logic [7:0]       res_mbx_reg, res_mby_reg;
  logic [SAD_W-1:0] res_sad_reg;
  logic [MV_W-1:0]  res_mvx_reg, res_mvy_reg;

  logic wd_expired;
  assign wd_expired = (wd_reg == WD_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (frame_start) state_next = S_LOAD;
      S_LOAD:   if (ld_ack) state_next = S_GO;
      S_GO:     state_next = S_WAIT;
      S_WAIT:   if (me_done || wd_expired) state_next = S_RESULT;
      S_RESULT: if (res_ready) state_next = S_NEXT;
      S_NEXT:   state_next = (mbx_reg == LAST_COL && mby_reg == LAST_ROW) ? S_FINISH : S_LOAD;
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      mbx_reg     <= '0;
      mby_reg     <= '0;
      wd_reg      <= '0;
      me_r_reg    <= '0;
      err_reg     <= 1'b0;
      res_mbx_reg <= '0;
      res_mby_reg <= '0;
      res_sad_reg <= '0;
      res_mvx_reg <= '0;
      res_mvy_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (frame_start) begin
            me_r_reg <= r;
            err_reg  <= 1'b0;
            mbx_reg  <= '0;
            mby_reg  <= '0;
          end
        end
        S_GO: wd_reg <= '0;
        S_WAIT: begin
          // A completion arriving on the expiry cycle takes priority over the watchdog.
          if (me_done) begin
            res_sad_reg <= me_sad;
            res_mvx_reg <= me_mvx;
            res_mvy_reg <= me_mvy;
            res_mbx_reg <= mbx_reg;
            res_mby_reg <= mby_reg;
          end else if (wd_expired) begin
            res_sad_reg <= '1;
            res_mvx_reg <= '0;
            res_mvy_reg <= '0;
            res_mbx_reg <= mbx_reg;
            res_mby_reg <= mby_reg;
            err_reg     <= 1'b1;
          end else begin
            wd_reg <= wd_reg + WD_W'(1);
          end
        end
        S_NEXT: begin
          if (mbx_reg == LAST_COL) begin
            mbx_reg <= '0;
            mby_reg <= mby_reg + 8'd1;
          end else begin
            mbx_reg <= mbx_reg + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_reg != S_IDLE);
  assign frame_done  = (state_reg == S_FINISH);
  assign err_timeout = err_reg;
  assign ld_req      = (state_reg == S_LOAD);
  assign ld_mbx      = mbx_reg;
  assign ld_mby      = mby_reg;
  assign me_go       = (state_reg == S_GO);
  assign me_r        = me_r_reg;
  assign res_valid   = (state_reg == S_RESULT);
  assign res_mbx     = res_mbx_reg;
  assign res_mby     = res_mby_reg;
  assign res_sad     = res_sad_reg;
  assign res_mvx     = res_mvx_reg;
  assign res_mvy     = res_mvy_reg;

endmodule

// File: tb/tb_me_frame_scheduler.sv
// Bench for me_frame_scheduler on a 2x2 grid with a short watchdog: table frames,
// an abort-by-reset sequence and randomized frames against a result model.
module tb_me_frame_scheduler;

  localparam int MBC = 2;
  localparam int MBR = 2;
  localparam int T   = 16;
  localparam int NMB = MBC * MBR;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic [1:0]  r = 2'd0;
  logic        busy, frame_done, err_timeout, ld_req, me_go, res_valid;
  logic [7:0]  ld_mbx, ld_mby, res_mbx, res_mby;
  logic [1:0]  me_r;
  logic        ld_ack = 1'b0;
  logic        me_done = 1'b0;
  logic [15:0] me_sad = 16'd0;
  logic [7:0]  me_mvx = 8'd0;
  logic [7:0]  me_mvy = 8'd0;
  logic        res_ready = 1'b1;
  logic [15:0] res_sad;
  logic [7:0]  res_mvx, res_mvy;
  logic [71:0] all_outs;

  me_frame_scheduler #(.MB_COLS(MBC), .MB_ROWS(MBR), .SAD_W(16), .MV_W(8), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .r(r), .busy(busy),
    .frame_done(frame_done), .err_timeout(err_timeout), .ld_req(ld_req), .ld_mbx(ld_mbx),
    .ld_mby(ld_mby), .ld_ack(ld_ack), .me_go(me_go), .me_r(me_r), .me_done(me_done),
    .me_sad(me_sad), .me_mvx(me_mvx), .me_mvy(me_mvy), .res_valid(res_valid),
    .res_ready(res_ready), .res_mbx(res_mbx), .res_mby(res_mby), .res_sad(res_sad),
    .res_mvx(res_mvx), .res_mvy(res_mvy)
  );

  always #5 clk = ~clk;

  assign all_outs = {busy, frame_done, err_timeout, ld_req, ld_mbx, ld_mby, me_go, me_r,
                     res_valid, res_mbx, res_mby, res_sad, res_mvx, res_mvy};

  typedef struct { int delay; logic [15:0] sad; logic [7:0] mvx; logic [7:0] mvy; } eng_t;
  typedef struct { logic [7:0] x; logic [7:0] y; logic [15:0] sad; logic [7:0] mvx; logic [7:0] mvy; } res_t;
  typedef struct {
    int ld_delay; int ready_low; int done_delay; logic [1:0] r;
    logic [15:0] sad; logic [7:0] mvx; logic [7:0] mvy;
    logic [15:0] exp_sad; logic [7:0] exp_mvx; logic [7:0] exp_mvy; logic exp_err;
  } vec_t;

  eng_t eng_q[$];
  res_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   ld_delay = 0;
  int   ready_low = 0;
  bit   rnd_ld = 1'b0;
  bit   rnd_rdy = 1'b0;
  logic [1:0] cur_r = 2'd0;
  int   go_cnt = 0;
  int   frame_done_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Result the engine contract implies: answers within the watchdog window are kept.
  function automatic res_t model(input int x, input int y, input eng_t en);
    res_t m;
    m.x = 8'(x);
    m.y = 8'(y);
    if (en.delay >= 1 && en.delay <= T) begin
      m.sad = en.sad; m.mvx = en.mvx; m.mvy = en.mvy;
    end else begin
      m.sad = 16'hFFFF; m.mvx = 8'd0; m.mvy = 8'd0;
    end
    return m;
  endfunction

  // Responders for load, engine and result port, plus latency/stability monitors.
  int   ld_wait, ld_target, ld_idx, eng_cnt, go_cyc, exp_lat, low_cnt, res_idx, post_acc;
  bit   ld_active, ld_stable, go_expect, wait_valid, in_valid, out_stable;
  logic [7:0] ld_x0, ld_y0;
  res_t snap, e;
  eng_t cur_eng;

  always @(negedge clk) begin
    if (frame_done) frame_done_cnt++;
    if (reset || !busy) begin
      ld_ack = 1'b0; me_done = 1'b0; res_ready = 1'b1;
      ld_active = 0; go_expect = 0; eng_cnt = 0; wait_valid = 0; in_valid = 0;
      low_cnt = 0; post_acc = 0; ld_idx = 0; res_idx = 0;
    end else begin
      ld_ack = 1'b0;
      if (go_expect || me_go) chk("go_after_ack", me_go, go_expect);
      go_expect = 0;

      me_done = 1'b0;
      me_sad = 16'($urandom); me_mvx = 8'($urandom); me_mvy = 8'($urandom);
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          me_done = 1'b1; me_sad = cur_eng.sad; me_mvx = cur_eng.mvx; me_mvy = cur_eng.mvy;
        end
      end
      go_cyc++;
      if (wait_valid && res_valid) begin
        chk("valid_latency", go_cyc, exp_lat);
        wait_valid = 0;
      end
      if (me_go) begin
        go_cnt++;
        chk("me_r", me_r, cur_r);
        if (eng_q.size() == 0) chk("engine_queue", eng_q.size(), 1);
        else begin
          cur_eng = eng_q.pop_front();
          eng_cnt = cur_eng.delay;
          go_cyc = 0;
          wait_valid = 1;
          exp_lat = ((cur_eng.delay >= 1 && cur_eng.delay <= T) ? cur_eng.delay : T) + 1;
        end
      end

      if (post_acc == 1) begin
        chk("gap_after_accept", {ld_req, frame_done, res_valid}, 3'b000);
        post_acc = 2;
      end else if (post_acc == 2) begin
        chk("next_after_accept", {ld_req, frame_done}, (res_idx == NMB) ? 2'b01 : 2'b10);
        post_acc = 0;
      end

      if (ld_req) begin
        if (!ld_active) begin
          ld_active = 1; ld_x0 = ld_mbx; ld_y0 = ld_mby; ld_stable = 1; ld_wait = 0;
          ld_target = rnd_ld ? int'($urandom_range(0, 3)) : ld_delay;
        end else if (ld_mbx !== ld_x0 || ld_mby !== ld_y0) begin
          ld_stable = 0;
        end
        if (ld_wait == ld_target) begin
          ld_ack = 1'b1; ld_active = 0; go_expect = 1;
          chk("ld_stable", ld_stable, 1);
          chk("ld_coord", {ld_x0, ld_y0}, {8'(ld_idx % MBC), 8'(ld_idx / MBC)});
          ld_idx++;
        end else begin
          ld_wait++;
        end
      end

      if (rnd_rdy) res_ready = 1'($urandom_range(0, 1));
      else res_ready = !(res_valid && low_cnt < ready_low);
      if (res_valid) begin
        if (!in_valid) begin
          in_valid = 1; out_stable = 1;
          snap.x = res_mbx; snap.y = res_mby; snap.sad = res_sad; snap.mvx = res_mvx; snap.mvy = res_mvy;
        end else if ({res_mbx, res_mby, res_sad, res_mvx, res_mvy} !==
                     {snap.x, snap.y, snap.sad, snap.mvx, snap.mvy}) begin
          out_stable = 0;
        end
        if (!res_ready) low_cnt++;
        else begin
          $display("result (%0d,%0d) sad=%h mvx=%0d mvy=%0d", res_mbx, res_mby, res_sad,
                   $signed(res_mvx), $signed(res_mvy));
          chk("result_stable", out_stable, 1);
          if (exp_q.size() == 0) chk("result_queue", exp_q.size(), 1);
          else begin
            e = exp_q.pop_front();
            chk("result", {res_mbx, res_mby, res_sad, res_mvx, res_mvy}, {e.x, e.y, e.sad, e.mvx, e.mvy});
          end
          in_valid = 0; low_cnt = 0; post_acc = 1; res_idx++;
        end
      end
    end
  end

  task automatic run_frame(input logic [1:0] rr, input bit exp_err, input int budget);
    int fd0;
    fd0 = frame_done_cnt;
    @(negedge clk);
    chk("idle_before_start", {busy, ld_req}, 2'b00);
    cur_r = rr; r = rr; frame_start = 1'b1;
    @(posedge clk); #2;
    chk("start_latency", {busy, ld_req, err_timeout, me_r}, {3'b110, rr});
    @(negedge clk);
    frame_start = 1'b0; r = 2'($urandom);
    for (int i = 0; i < budget && frame_done_cnt == fd0; i++) begin
      @(posedge clk); #2;
    end
    chk("frame_done_count", frame_done_cnt - fd0, 1);
    chk("frame_end", {busy, frame_done, err_timeout, me_r}, {2'b00, exp_err, rr});
    chk("results_left", exp_q.size(), 0);
    eng_q.delete(); exp_q.delete();
  endtask

  initial begin
    vec_t vecs [6];
    eng_t en;
    bit   exp_e;
    int   fd0;
    //          ld  rl  dly r     sad       mvx    mvy    exp_sad   exp_mvx exp_mvy err
    vecs[0] = '{0,  0,  5,  2'd2, 16'h0042, 8'h01, 8'hFF, 16'h0042, 8'h01,  8'hFF,  1'b0};
    vecs[1] = '{10, 7,  3,  2'd1, 16'h1234, 8'hFD, 8'h05, 16'h1234, 8'hFD,  8'h05,  1'b0};
    vecs[2] = '{0,  0,  0,  2'd3, 16'h5555, 8'h11, 8'h22, 16'hFFFF, 8'h00,  8'h00,  1'b1};
    vecs[3] = '{1,  2,  16, 2'd0, 16'h0BEE, 8'h07, 8'hF8, 16'h0BEE, 8'h07,  8'hF8,  1'b0};
    vecs[4] = '{0,  0,  17, 2'd2, 16'h7777, 8'h33, 8'h44, 16'hFFFF, 8'h00,  8'h00,  1'b1};
    vecs[5] = '{2,  1,  1,  2'd3, 16'hFFFE, 8'h80, 8'h7F, 16'hFFFE, 8'h80,  8'h7F,  1'b0};

    @(posedge clk); #2;
    chk("reset_outputs", all_outs, 0);
    @(negedge clk); reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      ld_delay = vecs[v].ld_delay; ready_low = vecs[v].ready_low; rnd_ld = 0; rnd_rdy = 0;
      for (int y = 0; y < MBR; y++)
        for (int x = 0; x < MBC; x++) begin
          eng_q.push_back('{vecs[v].done_delay, vecs[v].sad, vecs[v].mvx, vecs[v].mvy});
          exp_q.push_back('{8'(x), 8'(y), vecs[v].exp_sad, vecs[v].exp_mvx, vecs[v].exp_mvy});
        end
      run_frame(vecs[v].r, vecs[v].exp_err, 600);
    end

    // Abort the second macroblock's search with reset; busy-time frame_start and r are ignored.
    ld_delay = 0; ready_low = 0; rnd_ld = 0; rnd_rdy = 0; go_cnt = 0;
    eng_q.push_back('{3, 16'h0101, 8'h02, 8'h03});
    eng_q.push_back('{0, 16'h0000, 8'h00, 8'h00});
    exp_q.push_back('{8'd0, 8'd0, 16'h0101, 8'h02, 8'h03});
    fd0 = frame_done_cnt;
    @(negedge clk); cur_r = 2'd2; r = 2'd2; frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    for (int i = 0; i < 200 && go_cnt < 2; i++) begin
      @(posedge clk); #2;
    end
    chk("second_go_seen", go_cnt, 2);
    @(negedge clk); r = 2'd1; frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0; r = 2'd0;
    @(posedge clk); #2;
    chk("busy_start_ignored", {busy, ld_req, me_go, me_r}, {3'b100, 2'd2});
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #2;
    chk("reset_abort_outputs", all_outs, 0);
    @(negedge clk); reset = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    chk("no_frame_done_after_abort", frame_done_cnt - fd0, 0);
    chk("idle_after_abort", {busy, ld_req}, 2'b00);
    chk("abort_results_left", exp_q.size(), 0);
    eng_q.delete(); exp_q.delete();

    // Randomized frames; the first one also shows the restart from (0,0).
    for (int f = 0; f < 6; f++) begin
      rnd_ld = 1; rnd_rdy = 1; exp_e = 0;
      for (int y = 0; y < MBR; y++)
        for (int x = 0; x < MBC; x++) begin
          en.delay = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, T + 3));
          en.sad = 16'($urandom); en.mvx = 8'($urandom); en.mvy = 8'($urandom);
          eng_q.push_back(en);
          exp_q.push_back(model(x, y, en));
          if (!(en.delay >= 1 && en.delay <= T)) exp_e = 1;
        end
      run_frame(2'($urandom), exp_e, 800);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
